// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore decode of state, mem_ready-gated
// fetch/store writes, sticky illegal-opcode flag. Define MC_ADDI_EN to support addi (opcode 001000).
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_WB     = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    R_COMPLETE = 4'd7,
    BRANCH     = 4'd8,
    JUMP       = 4'd9,
    ADDI_EXEC  = 4'd10,
    ADDI_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   illegal_set;

  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw, instr_done_raw;

  // State and sticky illegal-opcode register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d           = FETCH;
    illegal_set       = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    instr_done_raw    = 1'b0;
    i_or_d            = 1'b0;
    mem_read          = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_d      = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:       state_d = ADDI_EXEC;
`endif
          default: begin
            state_d     = FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg     = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
      MEM_WRITE: begin
        mem_write_raw  = 1'b1;
        i_or_d         = 1'b1;
        instr_done_raw = mem_ready;
        state_d        = mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_COMPLETE;
      end
      R_COMPLETE: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'b01;
        instr_done_raw    = 1'b1;
        state_d           = FETCH;
      end
      JUMP: begin
        pc_write_raw   = 1'b1;
        pc_source      = 2'b10;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
`ifdef MC_ADDI_EN
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
    illegal_d = illegal_q | illegal_set;
  end

  // Write enables drop combinationally with rst so an in-flight store aborts at once
  assign pc_write      = pc_write_raw      & ~rst;
  assign pc_write_cond = pc_write_cond_raw & ~rst;
  assign mem_write     = mem_write_raw     & ~rst;
  assign ir_write      = ir_write_raw      & ~rst;
  assign reg_write     = reg_write_raw     & ~rst;
  assign instr_done    = instr_done_raw    & ~rst;
  assign illegal_op    = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; build with MC_ADDI_EN to exercise addi.
module tb_multicycle_control;

  logic       clk, rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH; per-cycle expectations packed with cycle 0 in the low bits
  task automatic run_seq(input string tag, input int n, input logic [31:0] st,
                         input logic [7:0] done_m, input logic [7:0] pcw_m,
                         input logic [15:0] aop, input logic [15:0] psrc);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s c%0d state", tag, i), {28'd0, state}, {28'd0, st[4*i +: 4]});
      check($sformatf("%s c%0d instr_done", tag, i), {31'd0, instr_done}, {31'd0, done_m[i]});
      check($sformatf("%s c%0d pc_write", tag, i), {31'd0, pc_write}, {31'd0, pcw_m[i]});
      check($sformatf("%s c%0d alu_op", tag, i), {30'd0, alu_op}, {30'd0, aop[2*i +: 2]});
      check($sformatf("%s c%0d pc_source", tag, i), {30'd0, pc_source}, {30'd0, psrc[2*i +: 2]});
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check("rst state", {28'd0, state}, 32'd0);
    check("rst pc_write", {31'd0, pc_write}, 32'd0);
    check("rst ir_write", {31'd0, ir_write}, 32'd0);
    check("rst mem_write", {31'd0, mem_write}, 32'd0);
    check("rst reg_write", {31'd0, reg_write}, 32'd0);
    check("rst instr_done", {31'd0, instr_done}, 32'd0);
    check("rst mem_read", {31'd0, mem_read}, 32'd1);
    check("rst alu_src_b", {30'd0, alu_src_b}, 32'd1);
    check("rst illegal_op", {31'd0, illegal_op}, 32'd0);
    rst = 1'b0;
    #1;
    check("fetch ir_write", {31'd0, ir_write}, 32'd1);
    check("fetch pc_write", {31'd0, pc_write}, 32'd1);
    check("fetch alu_src_b", {30'd0, alu_src_b}, 32'd1);

    // lw: 0,1,2,3,4
    opcode = 6'b100011;
    run_seq("lw", 4, 32'h0000_3210, 8'b00000, 8'b00001, 16'h0000, 16'h0000);
    check("lw wb state", {28'd0, state}, 32'd4);
    check("lw wb instr_done", {31'd0, instr_done}, 32'd1);
    check("lw wb mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    check("lw wb reg_write", {31'd0, reg_write}, 32'd1);
    step();

    // sw with three wait cycles in MEM_WRITE
    opcode = 6'b101011;
    run_seq("sw", 3, 32'h0000_0210, 8'b000, 8'b001, 16'h0000, 16'h0000);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sw wait%0d state", i), {28'd0, state}, 32'd5);
      check($sformatf("sw wait%0d mem_write", i), {31'd0, mem_write}, 32'd1);
      check($sformatf("sw wait%0d instr_done", i), {31'd0, instr_done}, 32'd0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("sw last mem_write", {31'd0, mem_write}, 32'd1);
    check("sw last instr_done", {31'd0, instr_done}, 32'd1);
    check("sw last i_or_d", {31'd0, i_or_d}, 32'd1);
    step();

    // R-type, beq, j
    opcode = 6'b000000;
    run_seq("rtype", 4, 32'h0000_7610, 8'b1000, 8'b0001, 16'h0020, 16'h0000);
    opcode = 6'b000100;
    run_seq("beq", 3, 32'h0000_0810, 8'b100, 8'b001, 16'h0010, 16'h0010);
    opcode = 6'b000010;
    run_seq("j", 3, 32'h0000_0910, 8'b100, 8'b101, 16'h0000, 16'h0020);

    // Illegal opcode then lw keeps the flag
    opcode = 6'b111111;
    check("pre illegal_op", {31'd0, illegal_op}, 32'd0);
    run_seq("illegal", 2, 32'h0000_0010, 8'b00, 8'b01, 16'h0000, 16'h0000);
    check("illegal set", {31'd0, illegal_op}, 32'd1);
    opcode = 6'b100011;
    run_seq("lw2", 5, 32'h0004_3210, 8'b10000, 8'b00001, 16'h0000, 16'h0000);
    check("illegal sticky", {31'd0, illegal_op}, 32'd1);
    check("lw2 back to fetch", {28'd0, state}, 32'd0);

    rst = 1'b1;
    #1;
    check("illegal cleared", {31'd0, illegal_op}, 32'd0);
    rst = 1'b0;
    #1;

    opcode = 6'b001000;
`ifdef MC_ADDI_EN
    run_seq("addi", 4, 32'h0000_BA10, 8'b1000, 8'b0001, 16'h0000, 16'h0000);
    check("addi legal", {31'd0, illegal_op}, 32'd0);
`else
    run_seq("addi", 2, 32'h0000_0010, 8'b00, 8'b01, 16'h0000, 16'h0000);
    check("addi illegal", {31'd0, illegal_op}, 32'd1);
`endif
    check("addi back to fetch", {28'd0, state}, 32'd0);

    // Reset in MEM_WRITE drops the store without a clock edge
    opcode = 6'b101011;
    run_seq("sw2", 3, 32'h0000_0210, 8'b000, 8'b001, 16'h0000, 16'h0000);
    mem_ready = 1'b0;
    #1;
    check("sw2 mem_write before rst", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("sw2 mem_write at rst", {31'd0, mem_write}, 32'd0);
    check("sw2 state at rst", {28'd0, state}, 32'd0);
    check("sw2 mem_read at rst", {31'd0, mem_read}, 32'd1);
    rst = 1'b0;
    mem_ready = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath, directly upstream of the ALU control block. Decodes the instruction opcode over several cycles and drives every datapath enable and mux select, including the 2-bit `alu_op` that the ALU control block combines with the function field. Handles memory wait states through a `mem_ready` handshake and keeps a sticky illegal-opcode flag.

## Interface
- No parameters. State encoding is fixed; see Operation.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from the instruction register; stable from the cycle after Fetch completes
- `mem_ready`  in  1  memory has completed the current access
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `ir_write`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls
- `alu_src_b`  out  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `alu_op`  out  2  to ALU control: 00 add, 01 subtract, 10 use func field
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `instr_done`  out  1  one-cycle pulse in an instruction's final cycle
- `illegal_op`  out  1  sticky flag, set on unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_COMPLETE=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12-15 are unreachable and go to FETCH.
- Outputs are Moore decodes of `state`, except that `mem_ready` gates the Fetch and store writes. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`. Holds until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC (macro only)
  - anything else -> FETCH and set `illegal_op`
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Goes to FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1, held until `mem_ready`. `instr_done`=`mem_ready`. Goes to FETCH on `mem_ready`.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_COMPLETE.
- R_COMPLETE: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Goes to FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- `illegal_op` is a register. It is set on the DECODE->FETCH edge for an illegal opcode and cleared only by `rst`.

## Timing
- On `rst` assertion, `state` goes to FETCH asynchronously and `illegal_op` clears.
- While `rst`=1, `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write` and `instr_done` are forced to 0, combinationally from `rst`.
- Values of the other outputs during reset: the FETCH decode, i.e. `mem_read`=1, `alu_src_b`=01, all others 0.
- After reset release, the first Fetch completes on the first edge at which `mem_ready`=1.
- Reset mid-instruction aborts immediately; an in-flight `mem_write` drops in the same cycle.
- Cycles per instruction with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle; outputs are held constant throughout.
- `mem_ready` is ignored in all other states.
- `opcode` is sampled in DECODE and MEM_ADDR only.

## Configuration
- `MC_ADDI_EN` defined: opcode 001000 is legal and uses ADDI_EXEC and ADDI_WB.
- `MC_ADDI_EN` undefined: opcode 001000 is illegal; states 10 and 11 do not exist and go to FETCH.

## Test plan
- Reset with `mem_ready`=1: `state`=0, all write enables 0 during `rst`. First edge after release: `pc_write`=`ir_write`=1, `alu_src_b`=01.
- lw (100011), `mem_ready`=1: state sequence 0,1,2,3,4,0; `instr_done` only in state 4, with `mem_to_reg`=`reg_write`=1.
- sw (101011) with `mem_ready` low for 3 cycles in MEM_WRITE: `mem_write` high for 4 cycles; `instr_done` pulses once, on the fourth.
- R-type then beq then j: `alu_op` reads 10 in EXECUTE, 01 in BRANCH; JUMP gives `pc_source`=10 and `pc_write`=1; 4, 3 and 3 cycles respectively.
- Opcode 111111: DECODE->FETCH in 2 cycles, `illegal_op`=1 and staying 1 across the following lw, cleared by `rst`. Opcode 001000 gives a 4-cycle addi with `MC_ADDI_EN` defined, and `illegal_op`=1 without it.
- `rst` asserted in MEM_WRITE with `mem_write`=1: `mem_write` drops the same cycle and `state`=0 with no clock edge.
